// File: rtl/sol_step_player.sv
// Captures the 8-puzzle start board and solver move list, then replays one move per debounced press.
// Define SOL_STEP_PLAYER_AUTO_PLAY_EN to also advance automatically every AUTO_PERIOD cycles in READY.
module sol_step_player #(
  parameter int MAX_STEPS   = 32,
  parameter int STEP_W      = 6,
  parameter int DEB_CYCLES  = 4,
  parameter int AUTO_PERIOD = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [35:0]       init_board,
  input  logic              load,
  input  logic              mv_valid,
  input  logic [1:0]        mv_dir,
  output logic              mv_ready,
  input  logic              sol_done,
  input  logic              btn,
  output logic [35:0]       board,
  output logic [3:0]        blank_pos,
  output logic [STEP_W-1:0] step,
  output logic [STEP_W-1:0] total,
  output logic              finished,
  output logic              err
);
  localparam int IDX_W  = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;
  localparam int DCNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

  if (STEP_W < $clog2(MAX_STEPS + 1) || DEB_CYCLES < 1 || AUTO_PERIOD < 1) begin : g_param_check
    $error("sol_step_player: invalid parameterisation");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_READY, S_APPLY, S_DONE, S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [35:0]         board_q, board_d;
  logic [3:0]          blank_q, blank_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [STEP_W-1:0]   total_q, total_d;
  logic                finished_q, finished_d;
  logic                err_q, err_d;
  logic                wr_en;
  logic                acc;
  logic                adv;
  logic [4:0]          blank_info;
  logic [4:0]          mv_info;
  logic [1:0]          buf_q [MAX_STEPS];

  // Returns {found, index} of the lowest cell holding the blank.
  function automatic logic [4:0] find_blank(input logic [35:0] b);
    logic [4:0] r;
    r = 5'd0;
    for (int i = 8; i >= 0; i--) begin
      if (b[4*i +: 4] == 4'd0) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

  // Returns {legal, neighbour cell} for moving the blank at pos in direction dir.
  function automatic logic [4:0] move_target(input logic [3:0] pos, input logic [1:0] dir);
    logic       ok;
    logic [3:0] nb;
    ok = 1'b0;
    nb = pos;
    case (dir)
      2'd0: begin ok = (pos >= 4'd3) && (pos <= 4'd8); nb = pos - 4'd3; end
      2'd1: begin ok = (pos <= 4'd5);                  nb = pos + 4'd3; end
      2'd2: begin
        ok = (pos <= 4'd8) && (pos != 4'd0) && (pos != 4'd3) && (pos != 4'd6);
        nb = pos - 4'd1;
      end
      default: begin
        ok = (pos <= 4'd7) && (pos != 4'd2) && (pos != 4'd5);
        nb = pos + 4'd1;
      end
    endcase
    return {ok, nb};
  endfunction

  // Button synchroniser, debouncer and registered rising-edge press.
  logic              sync1_q, sync2_q, lvl_q, lvl_d, press_q;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;

  always_comb begin
    lvl_d  = lvl_q;
    dcnt_d = '0;
    if (sync2_q != lvl_q) begin
      if (dcnt_q == DCNT_W'(DEB_CYCLES - 1)) lvl_d  = ~lvl_q;
      else                                   dcnt_d = dcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      lvl_q   <= 1'b0;
      dcnt_q  <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
      dcnt_q  <= dcnt_d;
      press_q <= lvl_d & ~lvl_q;
    end
  end

`ifdef SOL_STEP_PLAYER_AUTO_PLAY_EN
  localparam int ACNT_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  logic [ACNT_W-1:0] acnt_q, acnt_d;
  logic              auto_fire;

  always_comb begin
    auto_fire = (state_q == S_READY) && (acnt_q == ACNT_W'(AUTO_PERIOD - 1));
    acnt_d    = '0;
    if ((state_q == S_READY) && !press_q && !auto_fire) acnt_d = acnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acnt_q <= '0;
    else        acnt_q <= acnt_d;
  end

  assign adv = press_q | auto_fire;
`else
  assign adv = press_q;
`endif

  assign blank_info = find_blank(init_board);
  assign mv_info    = move_target(blank_q, buf_q[step_q[IDX_W-1:0]]);
  assign acc        = mv_valid & mv_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; load overrides everything.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = blank_info[4] ? S_COLLECT : S_ERR;
    end else begin
      case (state_q)
        S_COLLECT: if (sol_done) state_d = ((total_q != '0) || acc) ? S_READY : S_DONE;
        S_READY:   if (adv) state_d = S_APPLY;
        S_APPLY: begin
          if (!mv_info[4])                              state_d = S_ERR;
          else if ((step_q + STEP_W'(1)) == total_q)     state_d = S_DONE;
          else                                          state_d = S_READY;
        end
        default: ;
      endcase
    end
  end

  // Output and datapath next values.
  always_comb begin
    mv_ready = (state_q == S_COLLECT) && (total_q < STEP_W'(MAX_STEPS));
    board_d  = board_q;
    blank_d  = blank_q;
    step_d   = step_q;
    total_d  = total_q;
    wr_en    = 1'b0;
    if (load) begin
      board_d = init_board;
      blank_d = blank_info[3:0];
      step_d  = '0;
      total_d = '0;
    end else if ((state_q == S_COLLECT) && acc) begin
      total_d = total_q + STEP_W'(1);
      wr_en   = 1'b1;
    end else if ((state_q == S_APPLY) && mv_info[4]) begin
      board_d[4*blank_q +: 4]    = board_q[4*mv_info[3:0] +: 4];
      board_d[4*mv_info[3:0] +: 4] = 4'd0;
      blank_d = mv_info[3:0];
      step_d  = step_q + STEP_W'(1);
    end
    finished_d = (state_d == S_DONE);
    err_d      = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      board_q    <= '0;
      blank_q    <= '0;
      step_q     <= '0;
      total_q    <= '0;
      finished_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      board_q    <= board_d;
      blank_q    <= blank_d;
      step_q     <= step_d;
      total_q    <= total_d;
      finished_q <= finished_d;
      err_q      <= err_d;
    end
  end

  // Move storage carries no reset; total gates which entries are meaningful.
  always_ff @(posedge clk) begin
    if (wr_en) buf_q[total_q[IDX_W-1:0]] <= mv_dir;
  end

  assign board     = board_q;
  assign blank_pos = blank_q;
  assign step      = step_q;
  assign total     = total_q;
  assign finished  = finished_q;
  assign err       = err_q;
endmodule

// File: tb/tb_sol_step_player.sv
// Directed and randomized bench for sol_step_player with a cell-array reference model of the puzzle.
module tb_sol_step_player;
  localparam int MAX_STEPS   = 32;
  localparam int STEP_W      = 6;
  localparam int DEB_CYCLES  = 4;
  localparam int AUTO_PERIOD = 1000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [35:0]       init_board;
  logic              load;
  logic              mv_valid;
  logic [1:0]        mv_dir;
  logic              mv_ready;
  logic              sol_done;
  logic              btn;
  logic [35:0]       board;
  logic [3:0]        blank_pos;
  logic [STEP_W-1:0] step;
  logic [STEP_W-1:0] total;
  logic              finished;
  logic              err;

  sol_step_player #(
    .MAX_STEPS(MAX_STEPS), .STEP_W(STEP_W), .DEB_CYCLES(DEB_CYCLES), .AUTO_PERIOD(AUTO_PERIOD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .init_board(init_board), .load(load),
    .mv_valid(mv_valid), .mv_dir(mv_dir), .mv_ready(mv_ready), .sol_done(sol_done),
    .btn(btn), .board(board), .blank_pos(blank_pos), .step(step), .total(total),
    .finished(finished), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: puzzle as nine cells plus bookkeeping.
  int m_board [9];
  int m_blank;
  int m_step;
  int m_total;
  bit m_err;
  int m_moves [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_legal(input int pos, input int d);
    int r, c;
    r = pos / 3;
    c = pos % 3;
    case (d)
      0: return r > 0;
      1: return r < 2;
      2: return c > 0;
      default: return c < 2;
    endcase
  endfunction

  function automatic int model_nb(input int pos, input int d);
    case (d)
      0: return pos - 3;
      1: return pos + 3;
      2: return pos - 1;
      default: return pos + 1;
    endcase
  endfunction

  function automatic void model_load(input logic [35:0] b);
    m_blank = -1;
    for (int i = 0; i < 9; i++) begin
      m_board[i] = int'(b[4*i +: 4]);
      if (m_board[i] == 0 && m_blank < 0) m_blank = i;
    end
    m_err = (m_blank < 0);
    if (m_blank < 0) m_blank = 0;
    m_step  = 0;
    m_total = 0;
    m_moves.delete();
  endfunction

  function automatic logic [35:0] model_pack();
    logic [35:0] p;
    p = '0;
    for (int i = 0; i < 9; i++) p[4*i +: 4] = 4'(m_board[i]);
    return p;
  endfunction

  function automatic void model_press();
    int d, nb;
    if (m_err || m_step >= m_total) return;
    d = m_moves[m_step];
    if (!model_legal(m_blank, d)) begin
      m_err = 1'b1;
      return;
    end
    nb = model_nb(m_blank, d);
    m_board[m_blank] = m_board[nb];
    m_board[nb]      = 0;
    m_blank          = nb;
    m_step++;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [35:0] b);
    init_board = b;
    load = 1'b1;
    tick();
    load = 1'b0;
    model_load(b);
  endtask

  task automatic send_move(input int d, output bit accepted);
    accepted = 1'b0;
    mv_valid = 1'b1;
    mv_dir   = 2'(d);
    for (int k = 0; k < 4 && !accepted; k++) begin
      if (mv_ready) accepted = 1'b1;
      tick();
    end
    mv_valid = 1'b0;
    if (accepted && m_total < MAX_STEPS) begin
      m_moves.push_back(d);
      m_total++;
    end
  endtask

  task automatic pulse_done();
    sol_done = 1'b1;
    tick();
    sol_done = 1'b0;
  endtask

  task automatic press();
    btn = 1'b1;
    repeat (DEB_CYCLES + 5) tick();
    btn = 1'b0;
    repeat (DEB_CYCLES + 5) tick();
  endtask

  task automatic press_and_check(input string tag);
    press();
    model_press();
    check($sformatf("%s.board", tag), board, model_pack());
    check($sformatf("%s.blank", tag), blank_pos, m_blank);
    check($sformatf("%s.step", tag), step, m_step);
    check($sformatf("%s.err", tag), err, m_err);
    check($sformatf("%s.fin", tag), finished, (!m_err && m_step == m_total));
  endtask

  task automatic check_reset(input string tag);
    check($sformatf("%s.board", tag), board, 36'h0);
    check($sformatf("%s.blank", tag), blank_pos, 4'd0);
    check($sformatf("%s.step", tag), step, 0);
    check($sformatf("%s.total", tag), total, 0);
    check($sformatf("%s.ready", tag), mv_ready, 1'b0);
    check($sformatf("%s.fin", tag), finished, 1'b0);
    check($sformatf("%s.err", tag), err, 1'b0);
  endtask

  initial begin
    bit acc;
    int a [9];
    int pos, n, j, tmp, d, cnt, bad_at;
    logic [35:0] rb;

    rst_n = 1'b0; init_board = '0; load = 1'b0; mv_valid = 1'b0;
    mv_dir = 2'd0; sol_done = 1'b0; btn = 1'b0;
    #1;
    check_reset("por");
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Asynchronous reset in the middle of collecting.
    do_load(36'h123456780);
    send_move(3, acc); send_move(1, acc); send_move(2, acc);
    check("collect3.total", total, 3);
    check("collect3.ready", mv_ready, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_reset("async_rst");
    tick();
    rst_n = 1'b1;
    tick();

    // Latency: move accepted together with sol_done, then btn held.
    do_load(36'h807654321);
    check("lat.blank0", blank_pos, 4'd7);
    mv_valid = 1'b1; mv_dir = 2'd3; sol_done = 1'b1;
    tick();
    mv_valid = 1'b0; sol_done = 1'b0;
    m_moves.push_back(3); m_total = 1;
    check("lat.total", total, 1);
    btn = 1'b1;
    repeat (DEB_CYCLES + 3) tick();
    check("lat.early_board", board, 36'h807654321);
    tick();
    check("lat.board", board, 36'h087654321);
    check("lat.blank", blank_pos, 4'd8);
    check("lat.step", step, 1);
    check("lat.fin", finished, 1'b1);
    repeat (10 - (DEB_CYCLES + 4)) tick();
    btn = 1'b0;
    repeat (DEB_CYCLES + 5) tick();
    model_press();
    press_and_check("done_ignore");

    // Short glitches shorter than the debounce window.
    do_load(36'h123456780);
    send_move(3, acc); send_move(1, acc);
    pulse_done();
    check("glitch.total", total, 2);
    repeat (5) begin
      btn = 1'b1;
      repeat (DEB_CYCLES - 1) tick();
      btn = 1'b0;
      repeat (DEB_CYCLES - 1) tick();
    end
    repeat (DEB_CYCLES + 2) tick();
    check("glitch.step", step, 0);
    check("glitch.board", board, 36'h123456780);
    press_and_check("glitch.p1");
    press_and_check("glitch.p2");

    // Illegal move: blank at cell 8 moving right.
    do_load(36'h087654321);
    send_move(3, acc);
    pulse_done();
    press_and_check("illegal.p1");
    check("illegal.err_lit", err, 1'b1);
    check("illegal.board_lit", board, 36'h087654321);
    press_and_check("illegal.p2");

    // Loaded board without a blank.
    do_load(36'h987654321);
    check("noblank.err", err, 1'b1);
    check("noblank.ready", mv_ready, 1'b0);

    // Empty move list goes straight to finished.
    do_load(36'h123456780);
    pulse_done();
    check("empty.fin", finished, 1'b1);
    check("empty.total", total, 0);

    // Buffer capacity and full replay.
    do_load(36'h087654321);
    cnt = 0;
    for (int i = 0; i < MAX_STEPS; i++) begin
      send_move((i % 2 == 0) ? 2 : 3, acc);
      if (acc) cnt++;
    end
    check("full.accepted", cnt, MAX_STEPS);
    check("full.total", total, MAX_STEPS);
    check("full.ready", mv_ready, 1'b0);
    send_move(2, acc);
    check("full.33rd", acc, 1'b0);
    check("full.total2", total, MAX_STEPS);
    pulse_done();
    for (int i = 0; i < MAX_STEPS; i++) press_and_check($sformatf("full.p%0d", i));
    check("full.step", step, MAX_STEPS);
    check("full.fin", finished, 1'b1);

    // load in READY coinciding with a press.
    do_load(36'h123456780);
    send_move(3, acc); send_move(1, acc); send_move(2, acc);
    send_move(0, acc); send_move(3, acc);
    pulse_done();
    press_and_check("reload.p1");
    press_and_check("reload.p2");
    btn = 1'b1;
    repeat (DEB_CYCLES + 2) tick();
    init_board = 36'h087654321;
    load = 1'b1;
    tick();
    load = 1'b0;
    model_load(36'h087654321);
    check("reload.step", step, 0);
    check("reload.board", board, 36'h087654321);
    check("reload.total", total, 0);
    check("reload.ready", mv_ready, 1'b1);
    repeat (4) tick();
    check("reload.board_hold", board, 36'h087654321);
    btn = 1'b0;
    repeat (DEB_CYCLES + 5) tick();
    send_move(2, acc);
    pulse_done();
    press_and_check("reload.p3");

    // Randomized boards and walks, the last with an illegal move planted.
    for (int it = 0; it < 5; it++) begin
      for (int i = 0; i < 9; i++) a[i] = i;
      for (int i = 8; i > 0; i--) begin
        j = $urandom_range(0, i);
        tmp = a[i]; a[i] = a[j]; a[j] = tmp;
      end
      rb = '0;
      for (int i = 0; i < 9; i++) begin
        rb[4*i +: 4] = 4'(a[i]);
        if (a[i] == 0) pos = i;
      end
      do_load(rb);
      check($sformatf("rnd%0d.blank0", it), blank_pos, m_blank);
      n = $urandom_range(1, 6);
      bad_at = (it == 4) ? $urandom_range(0, n - 1) : -1;
      for (int k = 0; k < n; k++) begin
        d = $urandom_range(0, 3);
        if (k == bad_at) begin
          while (model_legal(pos, d)) d = $urandom_range(0, 3);
        end else begin
          while (!model_legal(pos, d)) d = $urandom_range(0, 3);
          pos = model_nb(pos, d);
        end
        send_move(d, acc);
      end
      pulse_done();
      check($sformatf("rnd%0d.total", it), total, m_total);
      for (int k = 0; k < n; k++) press_and_check($sformatf("rnd%0d.p%0d", it, k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
